// File: rtl/clk_en_mgr.sv
// Multi-channel fractional clock-enable generator with ordered per-channel bring-up.
// Latency: a phase-accumulator carry in cycle n appears on ce_out in cycle n+1; ready follows LOCK_CYC cycles of locking.
// Backpressure: none; enables are free-running pulses, and enable=0 parks every channel and the sequencer.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_b      synchronous active-low reset, highest priority
//   enable     global run request; low forces all channels OFF and the sequencer IDLE
//   inc        per-channel phase increments, channel i at [i*ACC_W +: ACC_W]
//   inc_load   per-channel strobe capturing its inc slice; relocks a running channel
//   ce_out     per-channel one-cycle enable pulses, rate f_clk*inc_reg/2^ACC_W
//   ready      per-channel locked indication
//   all_ready  AND of all ready bits
module clk_en_mgr #(
   parameter int NUM_CH   = 3,
   parameter int ACC_W    = 16,
   parameter int LOCK_CYC = 16,
   parameter int CH_GAP   = 8
) (
   input  logic                      clk,
   input  logic                      rst_b,
   input  logic                      enable,
   input  logic [NUM_CH*ACC_W-1:0]   inc,
   input  logic [NUM_CH-1:0]         inc_load,
   output logic [NUM_CH-1:0]         ce_out,
   output logic [NUM_CH-1:0]         ready,
   output logic                      all_ready
);

   localparam int CNT_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
   localparam int GAP_W = (CH_GAP > 1) ? $clog2(CH_GAP) : 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      CH_OFF     = 2'd0,
      CH_LOCKING = 2'd1,
      CH_LOCKED  = 2'd2
   } ch_state_t;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_WAIT = 2'd1,
      SEQ_GAP  = 2'd2,
      SEQ_RUN  = 2'd3
   } seq_state_t;

   logic [NUM_CH-1:0] start;

   // ------------------------------------------------------------------
   // Per-channel phase accumulator and lock FSM
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t        state_q, state_d;
      logic [ACC_W-1:0] acc_q, acc_d;
      logic [ACC_W-1:0] inc_q;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [ACC_W:0]   sum;
      logic [ACC_W-1:0] inc_slice;
      logic             ce_q, ce_d;

      assign inc_slice = inc[i*ACC_W +: ACC_W];
      // One extra bit keeps the carry; acc itself wraps modulo 2^ACC_W.
      assign sum       = {1'b0, acc_q} + {1'b0, inc_q};

      always_comb begin
         state_d = state_q;
         acc_d   = acc_q;
         cnt_d   = cnt_q;
         case (state_q)
            CH_OFF: begin
               acc_d = '0;
               cnt_d = '0;
               if (start[i]) state_d = CH_LOCKING;
            end
            CH_LOCKING: begin
               acc_d = sum[ACC_W-1:0];
               if (cnt_q == CNT_W'(LOCK_CYC-1)) begin
                  state_d = CH_LOCKED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            CH_LOCKED: begin
               acc_d = sum[ACC_W-1:0];
            end
            default: begin
               state_d = CH_OFF;
               acc_d   = '0;
               cnt_d   = '0;
            end
         endcase
         // A new increment on a running channel restarts its lock from phase zero.
         if (inc_load[i] && (state_q != CH_OFF)) begin
            state_d = CH_LOCKING;
            acc_d   = '0;
            cnt_d   = '0;
         end
         if (!enable) begin
            state_d = CH_OFF;
            acc_d   = '0;
            cnt_d   = '0;
         end
      end

      // Gating on the next state keeps ce_out a subset of ready, including
      // the cycle a channel drops out for relock or disable.
      assign ce_d = sum[ACC_W] && (state_d == CH_LOCKED);

      always_ff @(posedge clk) begin
         if (!rst_b) begin
            state_q <= CH_OFF;
            acc_q   <= '0;
            cnt_q   <= '0;
            inc_q   <= '0;
            ce_q    <= 1'b0;
         end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            if (inc_load[i]) inc_q <= inc_slice;
         end
      end

      assign ready[i]  = (state_q == CH_LOCKED);
      assign ce_out[i] = ce_q;
   end

   assign all_ready = &ready;

   // ------------------------------------------------------------------
   // Bring-up sequencer: starts channels in index order
   // ------------------------------------------------------------------
   seq_state_t        seq_q, seq_d;
   logic [CH_W-1:0]   ch_q, ch_d, ch_nxt;
   logic [GAP_W-1:0]  gap_q, gap_d;

   assign ch_nxt = ch_q + 1'b1;

   always_comb begin
      seq_d = seq_q;
      ch_d  = ch_q;
      gap_d = gap_q;
      start = '0;
      case (seq_q)
         SEQ_IDLE: begin
            if (enable) begin
               start[0] = 1'b1;
               ch_d     = '0;
               seq_d    = SEQ_WAIT;
            end
         end
         SEQ_WAIT: begin
            if (ready[ch_q]) begin
               if (ch_q == CH_W'(NUM_CH-1)) begin
                  seq_d = SEQ_RUN;
               end else if (CH_GAP == 1) begin
                  // Single-cycle gap: the cycle that sees ready is the gap.
                  start[ch_nxt] = 1'b1;
                  ch_d          = ch_nxt;
               end else begin
                  // The WAIT cycle that observed ready already counts as gap cycle 1.
                  seq_d = SEQ_GAP;
                  gap_d = GAP_W'(1);
               end
            end
         end
         SEQ_GAP: begin
            if (gap_q == GAP_W'(CH_GAP-1)) begin
               start[ch_nxt] = 1'b1;
               ch_d          = ch_nxt;
               gap_d         = '0;
               seq_d         = SEQ_WAIT;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         SEQ_RUN: begin
            seq_d = SEQ_RUN;
         end
         default: begin
            seq_d = SEQ_IDLE;
         end
      endcase
      if (!enable) begin
         seq_d = SEQ_IDLE;
         ch_d  = '0;
         gap_d = '0;
         start = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         seq_q <= SEQ_IDLE;
         ch_q  <= '0;
         gap_q <= '0;
      end else begin
         seq_q <= seq_d;
         ch_q  <= ch_d;
         gap_q <= gap_d;
      end
   end

endmodule

// File: tb/tb_clk_en_mgr.sv
// Bench for clk_en_mgr: schedule-based reference of lock timing and carry pattern,
// per-cycle scoreboard compare, table of rate windows, and hand-written corner sequences.
// Inputs change at the negedge; outputs are sampled at the negedge.
module tb_clk_en_mgr;

   localparam int NCH  = 3;
   localparam int W    = 16;
   localparam int LOCK = 16;
   localparam int GAP  = 8;

   logic               clk = 1'b0;
   logic               rst_b;
   logic               enable;
   logic [NCH*W-1:0]   inc;
   logic [NCH-1:0]     inc_load;
   logic [NCH-1:0]     ce_out;
   logic [NCH-1:0]     ready;
   logic               all_ready;

   clk_en_mgr #(
      .NUM_CH   (NCH),
      .ACC_W    (W),
      .LOCK_CYC (LOCK),
      .CH_GAP   (GAP)
   ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .enable    (enable),
      .inc       (inc),
      .inc_load  (inc_load),
      .ce_out    (ce_out),
      .ready     (ready),
      .all_ready (all_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0] rdy;
      logic [NCH-1:0] ce;
      logic           all_r;
   } exp_t;

   typedef struct {
      int         ch;
      logic [W-1:0] inc_v;
      int         win;
      int         nwin;
      int         exp_cnt;
      int         exp_gap;
   } rate_vec_t;

   exp_t       sb_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         t = 0;

   // Reference schedule: channel i enters LOCKING at edge lock_at[i] when on_m[i].
   logic         on_m    [NCH];
   int           lock_at [NCH];
   logic [W-1:0] inc_m   [NCH];
   logic         seq_idle = 1'b1;

   int           rise_t  [NCH];
   int           all_rise;
   int           pc      [NCH];
   int           early_ce = 0;
   logic [NCH-1:0] prev_rdy = '0;
   logic         prev_all = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp_v);
      end
   endtask

   // Carry out of accumulation step k, acc starting from zero.
   function automatic logic carry_at(input int k, input logic [W-1:0] iv);
      longint a, b, kk, ivl;
      kk  = longint'(k);
      ivl = longint'({48'b0, iv});
      a   = (kk * ivl) >>> W;
      b   = ((kk - 1) * ivl) >>> W;
      return (a != b);
   endfunction

   task automatic tick();
      exp_t e, got;
      int   tn;
      int   k;
      logic [6:0] obs;
      tn = t + 1;
      e  = '0;
      if (!rst_b) begin
         for (int i = 0; i < NCH; i++) begin
            on_m[i]  = 1'b0;
            inc_m[i] = '0;
         end
         seq_idle = 1'b1;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (inc_load[i]) begin
               if (enable && on_m[i] && (t >= lock_at[i])) lock_at[i] = tn;
               inc_m[i] = inc[i*W +: W];
            end
         end
         if (!enable) begin
            for (int i = 0; i < NCH; i++) on_m[i] = 1'b0;
            seq_idle = 1'b1;
         end else if (seq_idle) begin
            seq_idle = 1'b0;
            for (int i = 0; i < NCH; i++) begin
               on_m[i]    = 1'b1;
               lock_at[i] = tn + i * (LOCK + GAP);
            end
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (on_m[i] && (tn >= lock_at[i])) begin
            k         = tn - lock_at[i];
            e.rdy[i]  = (k >= LOCK);
            e.ce[i]   = (k >= LOCK) && carry_at(k, inc_m[i]);
         end
      end
      e.all_r = &e.rdy;
      sb_q.push_back(e);

      @(posedge clk);
      t = tn;
      @(negedge clk);

      if (sb_q.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
      end else begin
         got = sb_q.pop_front();
         obs = {ready, ce_out, all_ready};
         check("cyc", {57'b0, obs}, {57'b0, got});
      end
      for (int i = 0; i < NCH; i++) begin
         if (ready[i] && !prev_rdy[i]) rise_t[i] = t;
         if (ce_out[i]) pc[i]++;
         if (ce_out[i] && !ready[i]) early_ce++;
      end
      if (all_ready && !prev_all) all_rise = t;
      prev_rdy = ready;
      prev_all = all_ready;
   endtask

   task automatic clear_rise();
      for (int i = 0; i < NCH; i++) rise_t[i] = -1;
      all_rise = -1;
   endtask

   task automatic check_bringup(input int e0);
      for (int i = 0; i < NCH; i++)
         check($sformatf("rise%0d", i), 64'(rise_t[i]), 64'(e0 + (i+1)*LOCK + i*GAP));
      check("all_rise", 64'(all_rise), 64'(e0 + NCH*LOCK + (NCH-1)*GAP));
   endtask

   task automatic count_win(input int ch, input int n, input int exp_gap,
                            output int cnt, output int gap_bad);
      int last;
      cnt = 0;
      gap_bad = 0;
      last = -1;
      repeat (n) begin
         tick();
         if (ce_out[ch]) begin
            cnt++;
            if (exp_gap > 0 && last >= 0 && (t - last) != exp_gap) gap_bad++;
            last = t;
         end
      end
   endtask

   initial begin
      rate_vec_t rv[5];
      int e0, r_edge, cnt, gb;
      int pc0_s, pc1_s, pc2_s;

      rv[0] = '{ch: 0, inc_v: 16'h0000, win: 1000,  nwin: 1, exp_cnt: 0,     exp_gap: 0};
      rv[1] = '{ch: 2, inc_v: 16'hFFFF, win: 65536, nwin: 1, exp_cnt: 65535, exp_gap: 0};
      rv[2] = '{ch: 0, inc_v: 16'h2000, win: 800,   nwin: 1, exp_cnt: 100,   exp_gap: 8};
      rv[3] = '{ch: 1, inc_v: 16'h5000, win: 16,    nwin: 4, exp_cnt: 5,     exp_gap: 0};
      rv[4] = '{ch: 2, inc_v: 16'h4000, win: 64,    nwin: 1, exp_cnt: 16,    exp_gap: 4};

      for (int i = 0; i < NCH; i++) begin
         on_m[i] = 1'b0; lock_at[i] = 0; inc_m[i] = '0; pc[i] = 0;
      end
      clear_rise();
      rst_b = 1'b0; enable = 1'b0; inc = '0; inc_load = '0;

      // Reset state
      @(negedge clk);
      tick(); tick();
      check("rst_rdy", 64'(ready), 64'd0);
      check("rst_ce", 64'(ce_out), 64'd0);
      check("rst_all", 64'(all_ready), 64'd0);
      rst_b = 1'b1;
      tick();

      // 1. Load increments while OFF, then bring-up
      inc = {3{16'h4000}}; inc_load = '1;
      tick();
      inc_load = '0;
      check("off_rdy", 64'(ready), 64'd0);
      tick();
      enable = 1'b1;
      e0 = t + 1;
      clear_rise();
      repeat (70) tick();
      check_bringup(e0);

      // 2/3. Rate and boundary windows via relock in RUN
      for (int v = 0; v < 5; v++) begin
         inc[rv[v].ch*W +: W] = rv[v].inc_v;
         inc_load = '0;
         inc_load[rv[v].ch] = 1'b1;
         tick();
         inc_load = '0;
         repeat (LOCK) tick();
         check($sformatf("v%0d_rdy", v), 64'(ready[rv[v].ch]), 64'd1);
         for (int w = 0; w < rv[v].nwin; w++) begin
            count_win(rv[v].ch, rv[v].win, rv[v].exp_gap, cnt, gb);
            check($sformatf("v%0d_w%0d_cnt", v, w), 64'(cnt), 64'(rv[v].exp_cnt));
            check($sformatf("v%0d_w%0d_gap", v, w), 64'(gb), 64'd0);
         end
      end

      // 4. Relock channel 1 in RUN
      pc0_s = pc[0]; pc1_s = pc[1]; pc2_s = pc[2];
      inc[1*W +: W] = 16'h8000; inc_load = 3'b010;
      tick();
      r_edge = t;
      inc_load = '0;
      check("rl_rdy1", 64'(ready[1]), 64'd0);
      check("rl_all", 64'(all_ready), 64'd0);
      repeat (LOCK - 1) tick();
      check("rl_ch0_cnt", 64'(pc[0] - pc0_s), 64'd2);
      check("rl_ch2_cnt", 64'(pc[2] - pc2_s), 64'd4);
      check("rl_ch1_quiet", 64'(pc[1] - pc1_s), 64'd0);
      tick();
      check("rl_rise1", 64'(rise_t[1]), 64'(r_edge + LOCK));
      count_win(1, 20, 2, cnt, gb);
      check("rl_ch1_cnt", 64'(cnt), 64'd10);
      check("rl_ch1_gap", 64'(gb), 64'd0);

      // 5. Enable drop during GAP together with inc_load[0]
      enable = 1'b0;
      repeat (3) tick();
      check("drop_rdy", 64'(ready), 64'd0);
      enable = 1'b1;
      e0 = t + 1;
      repeat (20) tick();
      enable = 1'b0; inc[0 +: W] = 16'h1000; inc_load = 3'b001;
      tick();
      inc_load = '0;
      check("gapdrop_rdy", 64'(ready), 64'd0);
      check("gapdrop_ce", 64'(ce_out), 64'd0);
      check("gapdrop_all", 64'(all_ready), 64'd0);
      repeat (3) tick();
      enable = 1'b1;
      e0 = t + 1;
      clear_rise();
      repeat (70) tick();
      check_bringup(e0);
      count_win(0, 64, 16, cnt, gb);
      check("reen_ch0_cnt", 64'(cnt), 64'd4);
      check("reen_ch0_gap", 64'(gb), 64'd0);

      // 6. One-cycle reset in RUN with enable held high
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      check("rr_rdy", 64'(ready), 64'd0);
      check("rr_ce", 64'(ce_out), 64'd0);
      check("rr_all", 64'(all_ready), 64'd0);
      e0 = t + 1;
      clear_rise();
      pc0_s = pc[0]; pc1_s = pc[1]; pc2_s = pc[2];
      repeat (70) tick();
      check_bringup(e0);
      check("rr_inc_clr", 64'((pc[0] - pc0_s) + (pc[1] - pc1_s) + (pc[2] - pc2_s)), 64'd0);

      check("ce_wo_rdy", 64'(early_ce), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clk_en_mgr.md
Name: clk_en_mgr

Overview:
Parametrised multi-channel clock-enable manager. It generates NUM_CH fractional-rate clock-enable pulse trains from the single system clock using phase accumulators. Each channel has its own lock/ready indication, and channels are brought up in a fixed order: channel i+1 starts only after channel i is ready, plus a gap. It replaces per-frequency multiplier instances with one block that gives downstream logic ordered ready signals.

Parameters:
NUM_CH, 3, number of enable channels (1..8)
ACC_W, 16, phase accumulator / increment width in bits
LOCK_CYC, 16, cycles a channel spends in LOCKING before ready (>=1)
CH_GAP, 8, cycles between ready[i] rising and channel i+1 entering LOCKING (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
rst_b  in  1  synchronous, active-low reset
enable  in  1  global run request; low stops all channels
inc  in  NUM_CH*ACC_W  per-channel phase increment; channel i at [i*ACC_W +: ACC_W]
inc_load  in  NUM_CH  1-cycle strobe; captures inc slice i into inc_reg[i]
ce_out  out  NUM_CH  1-cycle clock-enable pulses; rate = f_clk*inc_reg/2^ACC_W
ready  out  NUM_CH  channel locked and producing enables
all_ready  out  1  AND of all ready bits (combinational from registers)

Behaviour:
- Reset (rst_b=0 at posedge): acc, inc_reg, ce_out, ready, all lock counters = 0; every channel OFF; sequencer IDLE. rst_b has priority over every other input.
- inc_reg[i] loads on inc_load[i] in any channel state, including OFF.
- Per-channel FSM:
  - OFF: acc held at 0; ready=0.
  - start[i] -> LOCKING: cnt=0, acc=0.
  - LOCKING: acc += inc_reg each cycle; cnt increments; at cnt==LOCK_CYC-1 -> LOCKED, ready[i]=1 from the next cycle.
  - LOCKED: acc keeps running.
  - inc_load[i] in LOCKING or LOCKED -> LOCKING next cycle: cnt=0, acc=0, ready[i]=0. This is a relock of that channel only; the sequencer does not re-run.
  - enable=0 in any state -> OFF next cycle. If inc_load arrives in the same cycle, inc_reg still loads and the channel goes OFF.
- Accumulator: the sum is computed ACC_W+1 bits wide; acc takes the low ACC_W bits and wraps modulo 2^ACC_W.
- ce_out[i] is registered: carry-out of cycle n appears as ce_out in cycle n+1, gated by ready[i]. There are no pulses during LOCKING or OFF.
- inc_reg=0 produces no pulses. The maximum increment 2^ACC_W-1 produces a pulse in all but one of every 2^ACC_W cycles.
- Sequencer FSM (IDLE, WAIT, GAP, RUN), with index ch:
  - IDLE: when enable=1, assert start[0] and go to WAIT with ch=0.
  - WAIT: when ready[ch]=1, go to RUN if ch==NUM_CH-1, else go to GAP with gap counter 0.
  - GAP: count CH_GAP cycles, then assert start[ch+1], ch++, go to WAIT.
  - RUN: stay while enable=1.
  - enable=0 in any state -> IDLE next cycle; ch=0.
- Bring-up timing: with enable sampled high at edge E0, ready[i] rises at edge E0 + (i+1)*LOCK_CYC + i*CH_GAP. With defaults: +16, +40, +64.
- A relock of channel i<ch during WAIT/GAP does not stall the sequence. all_ready drops for the duration of the relock.
- Re-asserting enable after a drop restarts the full sequence from channel 0 and keeps existing inc_reg values.

Test Plan:
1. Reset bring-up, defaults, inc all 0x4000 loaded while OFF; raise enable at E0 -> ready[0/1/2] rise at E0+16/+40/+64; all_ready at E0+64; no ce_out before the respective ready.
2. Rate check, ch0 inc=0x2000 -> after ready, exactly 100 ce_out[0] pulses in 800 cycles, each 8 cycles apart. Ch1 inc=0x5000 -> exactly 5 pulses in every 16-cycle window.
3. Boundaries: inc=0 -> zero pulses over 1000 cycles after ready. inc=0xFFFF -> 65535 pulses in 65536 cycles; acc wraps with no lost carry.
4. Relock: in RUN, pulse inc_load[1] with 0x8000 -> ready[1] and all_ready fall next cycle; ready[1] returns 16 cycles later; ce_out[1] then pulses every 2 cycles; ch0/ch2 pulse trains are uninterrupted.
5. Enable drop mid-sequence (GAP after ch0 ready), same cycle as inc_load[0]=0x1000 -> all ready/ce_out 0 next cycle; inc_reg[0]=0x1000; re-enable re-runs +16/+40/+64 timing.
6. rst_b=0 for one cycle while in RUN -> all outputs 0 next cycle, inc_reg cleared; with enable held high, the sequence restarts from channel 0.
